// File: rtl/l1_icache_ctrl.sv
// l1_icache_ctrl
// Sequencing controller for a direct-mapped L1 instruction store.
// The store has 2^INDEX_W lines, each holding one DATA_W-bit word and a tag.
// Hits are answered locally. A miss runs a req/ack refill from backing
// memory and fills the line. A whole-cache flush walks every index and
// clears its valid bit.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   clk_en     gates acceptance of new cpu_req/flush in IDLE only
//   cpu_req    fetch request (level), sampled in IDLE
//   read_addr  fetch word address, sampled with cpu_req
//   read_data  fetched instruction (registered)
//   data_ready one-cycle pulse, read_data valid
//   mem_req    refill request to backing memory (registered)
//   mem_addr   refill word address (registered)
//   mem_ack    backing memory returns mem_data this cycle
//   mem_data   refill word
//   flush      invalidate all lines, sampled in IDLE
//   busy       controller not in IDLE (combinational)
//   miss_count saturating miss counter
module l1_icache_ctrl #(
   parameter int ADDR_W  = 16,
   parameter int INDEX_W = 6,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [DATA_W-1:0] read_data,
   output logic              data_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              flush,
   output logic              busy,
   output logic [15:0]       miss_count
);

   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int LINES = 1 << INDEX_W;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_REFILL = 2'd2;
   localparam logic [1:0] S_FLUSH  = 2'd3;

   localparam logic [INDEX_W-1:0] LAST_IDX = '1;
   localparam logic [INDEX_W-1:0] IDX_ONE  = {{(INDEX_W-1){1'b0}}, 1'b1};

   logic [1:0]         state;
   logic [ADDR_W-1:0]  req_addr;
   logic [INDEX_W-1:0] flush_idx;
   logic [LINES-1:0]   valid;

   // Tag and data arrays carry no reset; valid bits alone qualify them.
   logic [DATA_W-1:0]  data_mem [LINES];
   logic [TAG_W-1:0]   tag_mem  [LINES];

   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic               hit;
   logic               fill;

   assign req_idx = req_addr[INDEX_W-1:0];
   assign req_tag = req_addr[ADDR_W-1:INDEX_W];
   assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);
   // mem_req is always high in REFILL, so an ack outside REFILL is ignored.
   assign fill    = (state == S_REFILL) && mem_ack;
   assign busy    = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         valid      <= '0;
         read_data  <= '0;
         data_ready <= 1'b0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         miss_count <= '0;
         flush_idx  <= '0;
         req_addr   <= '0;
      end else begin
         // data_ready is a single-cycle pulse; only the completing edge sets it.
         data_ready <= 1'b0;
         case (state)
            S_IDLE: begin
               // Flush wins over a simultaneous request; that request is dropped.
               if (clk_en && flush) begin
                  flush_idx <= '0;
                  state     <= S_FLUSH;
               end else if (clk_en && cpu_req) begin
                  req_addr <= read_addr;
                  state    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  read_data  <= data_mem[req_idx];
                  data_ready <= 1'b1;
                  state      <= S_IDLE;
               end else begin
                  mem_req  <= 1'b1;
                  mem_addr <= req_addr;
                  state    <= S_REFILL;
               end
            end
            S_REFILL: begin
               if (fill) begin
                  valid[req_idx] <= 1'b1;
                  read_data      <= mem_data;
                  data_ready     <= 1'b1;
                  mem_req        <= 1'b0;
                  if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                  state          <= S_IDLE;
               end
            end
            S_FLUSH: begin
               valid[flush_idx] <= 1'b0;
               flush_idx        <= flush_idx + IDX_ONE;
               if (flush_idx == LAST_IDX) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Array write on refill completion; a reset edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!rst && fill) begin
         data_mem[req_idx] <= mem_data;
         tag_mem[req_idx]  <= req_tag;
      end
   end

endmodule

// File: tb/tb_l1_icache_ctrl.sv
// tb_l1_icache_ctrl
// Directed bench for l1_icache_ctrl. A line-level model (valid/tag/data per
// index, miss counter) predicts hit or miss for each fetch; expected read
// words go into a queue that a per-cycle compare process drains whenever
// data_ready pulses. Literal checks pin the model on the known vectors.
module tb_l1_icache_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic        cpu_req = 1'b0;
   logic [15:0] read_addr = '0;
   logic [31:0] read_data;
   logic        data_ready;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_data = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic [15:0] miss_count;

   l1_icache_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .cpu_req    (cpu_req),
      .read_addr  (read_addr),
      .read_data  (read_data),
      .data_ready (data_ready),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_data   (mem_data),
      .flush      (flush),
      .busy       (busy),
      .miss_count (miss_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   // model and scoreboard
   bit          m_valid [64];
   logic [9:0]  m_tag   [64];
   logic [31:0] m_data  [64];
   logic [15:0] m_miss = '0;
   logic [31:0] exp_q [$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          exp_dr = 0;
   int          dr_seen = 0;
   bit          miss_window = 1'b0;
   logic [31:0] last_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_clear_valid();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
   endtask

   // per-cycle compare process
   always @(negedge clk) begin
      if (!rst) begin
         if (data_ready) begin
            dr_seen++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL spurious_data_ready: got read_data %h expected no pulse", read_data);
            end else begin
               check("read_data", read_data, exp_q.pop_front());
            end
         end
         check("mem_req_only_on_miss", {31'd0, mem_req & ~miss_window}, 32'd0);
      end
   end

   // driver tasks
   // One fetch: present the request, accept at the next edge, then watch
   // latency, answer a refill after ack_dly cycles if the model predicts a miss.
   task automatic fetch(input logic [15:0] a, input logic [31:0] fill_word, input int ack_dly);
      logic [5:0] ix;
      logic [9:0] tg;
      bit         hit;
      int         req_at;
      int         dr_at;
      ix  = a[5:0];
      tg  = a[15:6];
      hit = m_valid[ix] && (m_tag[ix] == tg);
      exp_q.push_back(hit ? m_data[ix] : fill_word);
      exp_dr++;
      miss_window = !hit;
      cpu_req   = 1'b1;
      read_addr = a;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      req_at = -1;
      dr_at  = -1;
      for (int n = 1; n <= 300 && dr_at < 0; n++) begin
         @(negedge clk);
         if (data_ready) begin
            dr_at   = n;
            last_rd = read_data;
            mem_ack = 1'b0;
         end else begin
            if (mem_req && req_at < 0) begin
               req_at = n;
               check("mem_addr", {16'd0, mem_addr}, {16'd0, a});
            end
            if (req_at >= 0 && n == req_at + ack_dly) begin
               mem_ack  = 1'b1;
               mem_data = fill_word;
            end
         end
      end
      mem_ack = 1'b0;
      if (hit) begin
         check("hit_no_mem_req", req_at, -1);
         check("hit_latency", dr_at, 2);
      end else begin
         check("miss_req_latency", req_at, 2);
         check("miss_ready_latency", dr_at, req_at + ack_dly + 1);
         m_valid[ix] = 1'b1;
         m_tag[ix]   = tg;
         m_data[ix]  = fill_word;
         if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
      end
      miss_window = 1'b0;
      check("miss_count", {16'd0, miss_count}, {16'd0, m_miss});
   endtask

   // Flush with an optional colliding request held for the first few cycles.
   task automatic do_flush(input bit with_req, input logic [15:0] a);
      int busy_cycles;
      bit done;
      flush     = 1'b1;
      cpu_req   = with_req;
      read_addr = a;
      @(posedge clk);
      #1;
      flush = 1'b0;
      busy_cycles = 0;
      done = 1'b0;
      for (int n = 1; n <= 300 && !done; n++) begin
         @(negedge clk);
         if (n == 10) cpu_req = 1'b0;
         if (busy) busy_cycles++;
         else done = 1'b1;
      end
      cpu_req = 1'b0;
      model_clear_valid();
      check("flush_busy_cycles", busy_cycles, 64);
   endtask

   // Reset arriving two cycles into REFILL, followed by a late ack.
   task automatic reset_mid_refill(input logic [15:0] a);
      bit seen;
      miss_window = 1'b1;
      cpu_req   = 1'b1;
      read_addr = a;
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      seen = 1'b0;
      for (int n = 1; n <= 50 && !seen; n++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      check("rst_test_mem_req_up", {31'd0, mem_req}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_refill_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mid_refill_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_refill_miss_count", {16'd0, miss_count}, 32'd0);
      rst      = 1'b0;
      mem_ack  = 1'b1;
      mem_data = 32'hdeadbeef;
      @(negedge clk);
      check("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
      check("late_ack_data_ready", {31'd0, data_ready}, 32'd0);
      check("late_ack_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      mem_ack = 1'b0;
      miss_window = 1'b0;
      model_clear_valid();
      m_miss = '0;
   endtask

   // stimulus
   initial begin
      model_clear_valid();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_read_data", read_data, 32'd0);
      check("reset_data_ready", {31'd0, data_ready}, 32'd0);
      check("reset_mem_req", {31'd0, mem_req}, 32'd0);
      check("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
      check("reset_miss_count", {16'd0, miss_count}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);

      // cold miss with ack three cycles after mem_req
      fetch(16'h000A, 32'h3c0207c3, 3);
      check("lit_first_read", last_rd, 32'h3c0207c3);
      check("lit_miss_count_1", {16'd0, miss_count}, 32'd1);

      // repeat fetch hits
      fetch(16'h000A, 32'h0, 0);
      check("lit_hit_read", last_rd, 32'h3c0207c3);
      check("lit_miss_count_still_1", {16'd0, miss_count}, 32'd1);

      // aliasing: same index, different tag, evict each other
      fetch(16'h004A, 32'h00622022, 2);
      check("lit_alias_read", last_rd, 32'h00622022);
      fetch(16'h000A, 32'h3c0207c3, 1);
      check("lit_miss_count_3", {16'd0, miss_count}, 32'd3);

      // flush beats a simultaneous request; next fetch misses
      do_flush(1'b1, 16'h000A);
      fetch(16'h000A, 32'h3c0207c3, 0);
      check("lit_miss_count_after_flush", {16'd0, miss_count}, 32'd4);

      // clk_en gating, then back-to-back hits
      fetch(16'h0155, 32'h0badf00d, 4);
      clk_en    = 1'b0;
      cpu_req   = 1'b1;
      read_addr = 16'h0155;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("clk_en_low_busy", {31'd0, busy}, 32'd0);
      end
      clk_en = 1'b1;
      fetch(16'h0155, 32'h0, 0);
      check("lit_clk_en_hit", last_rd, 32'h0badf00d);
      fetch(16'h000A, 32'h0, 0);
      fetch(16'h0155, 32'h0, 0);
      fetch(16'h000A, 32'h0, 0);
      check("lit_miss_count_5", {16'd0, miss_count}, 32'd5);

      // reset mid-refill, late ack ignored, line stays invalid
      reset_mid_refill(16'h0123);
      fetch(16'h0123, 32'h12345678, 1);
      check("lit_miss_after_reset", {16'd0, miss_count}, 32'd1);

      repeat (3) @(negedge clk);
      check("data_ready_pulse_count", dr_seen, exp_dr);
      check("exp_q_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/l1_icache_ctrl.md
Name: l1_icache_ctrl

Overview:
- Sequencing controller for the L1 instruction store.
- Direct-mapped, 64 lines, one 32-bit word per line, word-addressed 16-bit fetch addresses.
- Performs the tag check and answers hits locally. On a miss, runs a req/ack refill from backing memory, then fills the line.
- Supports a whole-cache flush. Sits between the fetch stage and the memory port.

Parameters:
- ADDR_W, 16, fetch/memory word-address width
- INDEX_W, 6, line index width (2^INDEX_W lines)
- DATA_W, 32, instruction word width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  gates acceptance of new cpu_req/flush only
- cpu_req  in  1  fetch request, level, sampled in IDLE
- read_addr  in  ADDR_W  fetch word address, sampled with cpu_req
- read_data  out  DATA_W  fetched instruction, registered
- data_ready  out  1  one-cycle pulse, read_data valid
- mem_req  out  1  refill request to backing memory, registered
- mem_addr  out  ADDR_W  refill word address, registered
- mem_ack  in  1  backing memory returns mem_data this cycle
- mem_data  in  DATA_W  refill word
- flush  in  1  invalidate all lines, sampled in IDLE
- busy  out  1  state != IDLE, combinational
- miss_count  out  16  saturating miss counter

Behaviour:
- Clock and reset:
  - Single clock domain. rst is synchronous and active-high.
  - Reset values: state=IDLE, all valid bits=0, read_data=0, data_ready=0, mem_req=0, mem_addr=0, miss_count=0, busy=0.
  - Tag and data arrays are not reset.
- Address split: index=addr[INDEX_W-1:0]; tag=addr[ADDR_W-1:INDEX_W] (10 bits at default parameters).
- IDLE:
  - If clk_en=1 and flush=1: go to FLUSH with flush_idx=0. Flush wins over a simultaneous cpu_req, which is ignored and must be re-presented.
  - Else if clk_en=1 and cpu_req=1: latch read_addr, go to LOOKUP.
  - clk_en=0: stay in IDLE.
- LOOKUP:
  - Hit (valid[idx] and tag[idx]==latched tag): read_data<=data[idx], data_ready<=1, go to IDLE.
  - Miss: mem_req<=1, mem_addr<=latched addr, go to REFILL.
- REFILL:
  - mem_req is held at 1 until mem_ack.
  - On mem_ack=1: data[idx]<=mem_data, tag[idx]<=latched tag, valid[idx]<=1, read_data<=mem_data, data_ready<=1, mem_req<=0, miss_count+=1 (saturates at 16'hFFFF), go to IDLE.
  - mem_ack while mem_req=0 is ignored.
- FLUSH:
  - Clears valid[flush_idx] each cycle and increments flush_idx.
  - After index 2^INDEX_W-1 is cleared, go to IDLE. Duration is 64 cycles; busy=1 throughout.
- Latency:
  - Hit: request accepted at edge T, data_ready=1 in the cycle following edge T+1 (2 cycles).
  - Miss: mem_req rises after edge T+1. data_ready is asserted the cycle after the mem_ack edge.
- data_ready:
  - High for exactly one cycle per accepted request. Cleared at every other edge.
  - In the data_ready cycle, state is IDLE, so a back-to-back request is accepted.
- cpu_req/flush outside IDLE: ignored; no queueing.
- clk_en: affects only acceptance in IDLE. An in-flight LOOKUP/REFILL/FLUSH completes regardless of clk_en.
- Reset mid-operation:
  - Mid-REFILL: mem_req=0 after the reset edge; a late mem_ack is ignored; no line is written.
  - Mid-FLUSH: reset clears all valid bits at once.
- Aliasing: addresses with equal index and different tag evict each other; the last refill wins.

Test Plan:
- Reset, then request addr 16'h000A with mem_ack returning 32'h3c0207c3 three cycles after mem_req -> mem_addr=16'h000A; data_ready pulses once with read_data=32'h3c0207c3; miss_count=1.
- Repeat fetch of 16'h000A -> no mem_req; data_ready exactly 2 cycles after acceptance with 32'h3c0207c3; miss_count stays 1.
- Fetch 16'h004A (same index 10, tag 1) -> miss, refill 32'h00622022. Then fetch 16'h000A -> miss again; miss_count=3.
- Assert flush and cpu_req together in IDLE -> busy high 64 cycles, request ignored. Subsequent fetch of 16'h000A misses.
- Assert rst two cycles into REFILL, then assert mem_ack -> mem_req=0, no data_ready, line stays invalid; next fetch of that address misses.
- Hold clk_en=0 with cpu_req=1 -> no transition, busy=0. Raise clk_en -> request accepted next edge. Issue back-to-back hits -> one data_ready per request, none lost.
